fp_mul_seq_ctrl: RTL and testbench

Sequencer for the 32-bit floating-point multiplier datapath. Accepts a start request with operands already presented on the datapath operand buses, then drives the datapath register write enables (operand registers, exponent-sum register, biased-exponent register) and the mantissa multiplier start in the required order. It waits for the multiplier's done flag, short-circuits when the zero-detect flag fires, and hands the result back with a done/ack handshake. It sits between the system bus front end and the multiplier datapath, as the only driver of the datapath's enable inputs.

---
 rtl/fp_mul_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_fp_mul_seq_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fp_mul_seq_ctrl.sv
// Sequencer for the 32-bit FP multiplier datapath: orders the register enables and the
// mantissa-multiplier start. Optional MUL_WAIT timeout abort is built with FPMC_TIMEOUT_EN.
module fp_mul_seq_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic ack,
    input  logic mul_done,
    input  logic is_zero,
    output logic reg_1_e,
    output logic reg_2_e,
    output logic rwe_a,
    output logic rwe_b,
    output logic mul_enable,
    output logic busy,
    output logic done,
    output logic zero_res,
    output logic err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXP,
        S_CHK,
        S_BIAS,
        S_MUL_WAIT,
        S_DONE
    } state_e;

    state_e state_q, state_d;
    logic   zero_res_q, zero_res_d;
    logic   err_q, err_d;
    logic   first_q, first_d;
    logic   timeout;

`ifdef FPMC_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == S_BIAS) begin
            to_cnt_d = '0;
        end else if (state_q == S_MUL_WAIT) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    // to_cnt_d is the number of MUL_WAIT cycles including the current one.
    assign timeout = (state_q == S_MUL_WAIT) && (to_cnt_d == TO_W'(TIMEOUT_CYCLES));
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYCLES, TO_W};
    assign timeout    = 1'b0;
`endif

    // The multiplier's done flag may still be high from the previous operation.
    assign first_d = (state_q == S_BIAS);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d    = state_q;
        zero_res_d = zero_res_q;
        err_d      = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    zero_res_d = 1'b0;
                    err_d      = 1'b0;
                end
            end
            S_LOAD: state_d = S_EXP;
            S_EXP:  state_d = S_CHK;
            S_CHK: begin
                if (is_zero) begin
                    state_d    = S_DONE;
                    zero_res_d = 1'b1;
                end else begin
                    state_d = S_BIAS;
                end
            end
            S_BIAS: state_d = S_MUL_WAIT;
            S_MUL_WAIT: begin
                if (mul_done && !first_q) begin
                    state_d = S_DONE;
                end else if (timeout) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_DONE: begin
                if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!reset) begin
            state_q    <= S_IDLE;
            zero_res_q <= 1'b0;
            err_q      <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            zero_res_q <= zero_res_d;
            err_q      <= err_d;
            first_q    <= first_d;
        end
    end

    assign reg_1_e    = (state_q == S_LOAD);
    assign reg_2_e    = (state_q == S_LOAD);
    assign rwe_a      = (state_q == S_EXP);
    assign rwe_b      = (state_q == S_BIAS);
    assign mul_enable = (state_q == S_MUL_WAIT);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign zero_res   = zero_res_q;
    assign err        = err_q;

endmodule

// File: tb/tb_fp_mul_seq_ctrl.sv
// Randomized bench for fp_mul_seq_ctrl: each operation's per-cycle output trace is derived
// from cycle-offset timing rules and compared every cycle.
module tb_fp_mul_seq_ctrl;

    localparam int T = 8;

    logic clk = 1'b0;
    logic reset, start, ack, mul_done, is_zero;
    logic reg_1_e, reg_2_e, rwe_a, rwe_b, mul_enable, busy, done, zero_res, err;

    int n_checks = 0;
    int n_errors = 0;
    int op_id    = 0;
    bit zr_prev  = 1'b0;
    bit er_prev  = 1'b0;

    wire [8:0] obs_v = {reg_1_e, reg_2_e, rwe_a, rwe_b, mul_enable, busy, done, zero_res, err};

    fp_mul_seq_ctrl #(.TIMEOUT_CYCLES(T), .TO_W(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ack        (ack),
        .mul_done   (mul_done),
        .is_zero    (is_zero),
        .reg_1_e    (reg_1_e),
        .reg_2_e    (reg_2_e),
        .rwe_a      (rwe_a),
        .rwe_b      (rwe_b),
        .mul_enable (mul_enable),
        .busy       (busy),
        .done       (done),
        .zero_res   (zero_res),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] pk(bit ld, bit ea, bit eb, bit me, bit bz, bit dn, bit zr, bit er);
        return {ld, ld, ea, eb, me, bz, dn, zr, er};
    endfunction

    // One operation: start sampled at edge 0, outputs checked mid-cycle for cycles 1..ack cycle.
    // n: mul_done is driven high in cycle 5+n. abort_at: reset asserted in that cycle (0 = none).
    task automatic run_op(input bit iz, input int n, input int ack_dly, input int abort_at);
        bit tmo;
        int dfirst;
        int ack_c;
        op_id++;
        @(negedge clk);
        check($sformatf("op%0d idle", op_id), obs_v, pk(0, 0, 0, 0, 0, 0, zr_prev, er_prev));
        start = 1'b1;
        ack   = 1'b0;
`ifdef FPMC_TIMEOUT_EN
        tmo = !iz && (n >= T);
`else
        tmo = 1'b0;
`endif
        dfirst = iz ? 4 : (tmo ? 5 + T : 6 + n);
        ack_c  = dfirst + ack_dly;
        for (int c = 1; c <= ack_c; c++) begin
            @(negedge clk);
            check($sformatf("op%0d c%0d", op_id, c), obs_v,
                  pk(c == 1, c == 2, !iz && c == 4, !iz && c >= 5 && c < dfirst, 1'b1,
                     c >= dfirst, iz && c >= 4, tmo && c >= dfirst));
            if (c == abort_at) begin
                #2 reset = 1'b0;
                #1 check($sformatf("op%0d reset_async", op_id), obs_v, 9'd0);
                @(posedge clk);
                @(negedge clk);
                check($sformatf("op%0d reset_hold", op_id), obs_v, 9'd0);
                reset   = 1'b1;
                start   = 1'b0;
                mul_done = 1'b0;
                zr_prev = 1'b0;
                er_prev = 1'b0;
                return;
            end
            start    = 1'($urandom_range(0, 1));
            is_zero  = (c == 3) ? iz : 1'($urandom_range(0, 1));
            mul_done = (c == 5 + n) ? 1'b1 : ((c <= 5) ? 1'($urandom_range(0, 1)) : 1'b0);
            ack      = (c < dfirst) ? 1'($urandom_range(0, 1)) : (c == ack_c);
        end
        start   = 1'b0;
        zr_prev = iz;
        er_prev = tmo;
    endtask

    task automatic idle_gap(input int k);
        repeat (k) begin
            @(negedge clk);
            check("gap idle", obs_v, pk(0, 0, 0, 0, 0, 0, zr_prev, er_prev));
            ack      = 1'($urandom_range(0, 1));
            mul_done = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        ack      = 1'b0;
        mul_done = 1'b0;
        is_zero  = 1'b0;
        @(negedge clk);
        check("reset outputs", obs_v, 9'd0);
        start = 1'b1;
        @(negedge clk);
        check("reset holds start off", obs_v, 9'd0);
        start = 1'b0;
        reset = 1'b1;

        run_op(1'b0, 10, 0, 8);   // reset while in MUL_WAIT
        run_op(1'b0, 10, 0, 0);   // normal, mul_done 10 cycles after mul_enable
        run_op(1'b1, 3, 0, 0);    // zero short-circuit
        run_op(1'b0, 2, 5, 0);    // ack withheld, start toggling
        run_op(1'b0, 1, 0, 0);    // back-to-back pair
        run_op(1'b1, 1, 0, 0);
`ifdef FPMC_TIMEOUT_EN
        run_op(1'b0, 20, 0, 0);   // mul_done never arrives in time
        run_op(1'b0, T - 1, 0, 0); // mul_done at the terminal count
        run_op(1'b0, T, 1, 0);
`endif
        for (int i = 0; i < 40; i++) begin
            idle_gap($urandom_range(0, 2));
            run_op($urandom_range(0, 3) == 0, $urandom_range(1, 20), $urandom_range(0, 4), 0);
        end
        idle_gap(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
